aemb2_wbk: RTL and testbench

Data-memory access and writeback stage of the AEMB2 pipeline, downstream of the decode/control stage. Takes the EX-stage result and writeback selector, runs the data-bus (DWB) transaction for loads and stores, stalls the whole pipeline through `dena` while the bus is pending, and drives the register-file write port with the selected, lane-aligned result.

---
 rtl/aemb2_pkg.sv | 22 ++
 rtl/aemb2_lane.sv | 51 +++++
 rtl/aemb2_wbk.sv | 136 +++++++++++++
 tb/tb_aemb2_wbk.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aemb2_pkg.sv
// Shared constants for the AEMB2 data-memory/writeback stage:
// writeback selectors, access sizes and the bus FSM state encoding.
package aemb2_pkg;

    localparam logic [2:0] MUX_NOP = 3'd0;
    localparam logic [2:0] MUX_ALU = 3'd1;
    localparam logic [2:0] MUX_RPC = 3'd2;
    localparam logic [2:0] MUX_MEM = 3'd4;
    localparam logic [2:0] MUX_MUL = 3'd5;
    localparam logic [2:0] MUX_BSF = 3'd6;
    localparam logic [2:0] MUX_SFR = 3'd7;

    localparam logic [1:0] SIZ_BYTE = 2'd0;
    localparam logic [1:0] SIZ_HALF = 2'd1;
    localparam logic [1:0] SIZ_WORD = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } wbk_state_t;

endpackage

// File: rtl/aemb2_lane.sv
// Big-endian byte-lane logic: lane enables from size/address, store data
// replication, and right-justified zero-extended load extraction.
module aemb2_lane
    import aemb2_pkg::*;
(
    input  logic [1:0]  i_siz,
    input  logic [1:0]  i_adr,
    input  logic [31:0] i_opd,
    input  logic [3:0]  i_sel_mx,
    input  logic [31:0] i_dat,
    output logic [3:0]  o_sel,
    output logic [31:0] o_dat_st,
    output logic [31:0] o_dat_ld
);

    always_comb begin
        o_sel    = 4'b1111;
        o_dat_st = i_opd;
        case (i_siz)
            SIZ_BYTE: begin
                o_dat_st = {4{i_opd[7:0]}};
                case (i_adr)
                    2'd0:    o_sel = 4'b1000;
                    2'd1:    o_sel = 4'b0100;
                    2'd2:    o_sel = 4'b0010;
                    default: o_sel = 4'b0001;
                endcase
            end
            SIZ_HALF: begin
                o_dat_st = {2{i_opd[15:0]}};
                o_sel    = i_adr[1] ? 4'b0011 : 4'b1100;
            end
            default: ;
        endcase
    end

    // Load extraction is keyed on the lanes latched with the access in MX.
    always_comb begin
        o_dat_ld = i_dat;
        case (i_sel_mx)
            4'b1000: o_dat_ld = {24'd0, i_dat[31:24]};
            4'b0100: o_dat_ld = {24'd0, i_dat[23:16]};
            4'b0010: o_dat_ld = {24'd0, i_dat[15:8]};
            4'b0001: o_dat_ld = {24'd0, i_dat[7:0]};
            4'b1100: o_dat_ld = {16'd0, i_dat[31:16]};
            4'b0011: o_dat_ld = {16'd0, i_dat[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/aemb2_wbk.sv
// AEMB2 data-memory access and writeback stage: runs the DWB transaction,
// stalls the pipeline via dena while pending, and drives the RF write port.
module aemb2_wbk
    import aemb2_pkg::*;
#(
    parameter int AEMB_DWB = 32
) (
    input  logic                gclk,
    input  logic                grst,
    input  logic                iena,
    input  logic [2:0]          mux_ex,
    input  logic [4:0]          rd_ex,
    input  logic                str_ex,
    input  logic [1:0]          siz_ex,
    input  logic [31:0]         alu_ex,
    input  logic [31:0]         opd_ex,
    input  logic [31:0]         rpc_ex,
    input  logic [31:0]         sfr_ex,
    input  logic [31:0]         mul_mx,
    input  logic [31:0]         bsf_mx,
    output logic [AEMB_DWB-3:0] dwb_adr_o,
    output logic [3:0]          dwb_sel_o,
    output logic [31:0]         dwb_dat_o,
    output logic                dwb_wre_o,
    output logic                dwb_stb_o,
    input  logic                dwb_ack_i,
    input  logic [31:0]         dwb_dat_i,
    output logic                dena,
    output logic                rf_we,
    output logic [4:0]          rf_wa,
    output logic [31:0]         rf_wd
);

    wbk_state_t          r_state, w_state_nxt;
    logic [AEMB_DWB-3:0] r_adr;
    logic [3:0]          r_sel;
    logic [31:0]         r_dat;
    logic                r_wre;
    logic [2:0]          r_mux_mx;
    logic [4:0]          r_rd_mx;
    logic [3:0]          r_sel_mx;
    logic [31:0]         r_res_mx;

    logic                w_dena, w_launch;
    logic [3:0]          w_sel;
    logic [31:0]         w_dat_st, w_dat_ld, w_res, w_wd;

    aemb2_lane u_lane (
        .i_siz    (siz_ex),
        .i_adr    (alu_ex[1:0]),
        .i_opd    (opd_ex),
        .i_sel_mx (r_sel_mx),
        .i_dat    (dwb_dat_i),
        .o_sel    (w_sel),
        .o_dat_st (w_dat_st),
        .o_dat_ld (w_dat_ld)
    );

    assign dwb_stb_o = (r_state == ST_BUSY);
    assign w_dena    = iena & ~(dwb_stb_o & ~dwb_ack_i);
    assign w_launch  = w_dena & ((mux_ex == MUX_MEM) | str_ex);

    // Leaving BUSY needs dena, so an ack during an iena stall keeps stb up.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_launch) w_state_nxt = ST_BUSY;
            ST_BUSY: if (dwb_ack_i && w_dena) w_state_nxt = w_launch ? ST_BUSY : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            r_adr <= '0;
            r_sel <= '0;
            r_dat <= '0;
            r_wre <= 1'b0;
        end else if (w_launch) begin
            r_adr <= alu_ex[AEMB_DWB-1:2];
            r_sel <= w_sel;
            r_dat <= w_dat_st;
            r_wre <= str_ex;
        end
    end

    assign dwb_adr_o = r_adr;
    assign dwb_sel_o = r_sel;
    assign dwb_dat_o = r_dat;
    assign dwb_wre_o = r_wre;

    always_comb begin
        w_res = alu_ex;
        case (mux_ex)
            MUX_RPC: w_res = rpc_ex;
            MUX_SFR: w_res = sfr_ex;
            default: ;
        endcase
    end

    // EX -> MX boundary; stores never write the register file.
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            r_mux_mx <= MUX_NOP;
            r_rd_mx  <= '0;
            r_sel_mx <= '0;
            r_res_mx <= '0;
        end else if (w_dena) begin
            r_mux_mx <= str_ex ? MUX_NOP : mux_ex;
            r_rd_mx  <= rd_ex;
            r_sel_mx <= w_sel;
            r_res_mx <= w_res;
        end
    end

    always_comb begin
        w_wd = r_res_mx;
        case (r_mux_mx)
            MUX_MEM: w_wd = w_dat_ld;
            MUX_MUL: w_wd = mul_mx;
            MUX_BSF: w_wd = bsf_mx;
            default: ;
        endcase
    end

    assign dena  = w_dena;
    assign rf_we = w_dena & (r_mux_mx != MUX_NOP) & (r_rd_mx != 5'd0);
    assign rf_wa = r_rd_mx;
    assign rf_wd = w_wd;

endmodule

// File: tb/tb_aemb2_wbk.sv
// Scoreboard bench for aemb2_wbk: a transaction-level model queues expected
// bus accesses and register writes; a negedge monitor pops and compares.
module tb_aemb2_wbk;

    logic        gclk = 1'b0;
    logic        grst, iena, str_ex, dwb_ack_i;
    logic [2:0]  mux_ex;
    logic [4:0]  rd_ex;
    logic [1:0]  siz_ex;
    logic [31:0] alu_ex, opd_ex, rpc_ex, sfr_ex, mul_mx, bsf_mx, dwb_dat_i;
    logic [29:0] dwb_adr_o;
    logic [3:0]  dwb_sel_o;
    logic [31:0] dwb_dat_o, rf_wd;
    logic        dwb_wre_o, dwb_stb_o, dena, rf_we;
    logic [4:0]  rf_wa;

    aemb2_wbk #(.AEMB_DWB(32)) dut (
        .gclk(gclk), .grst(grst), .iena(iena),
        .mux_ex(mux_ex), .rd_ex(rd_ex), .str_ex(str_ex), .siz_ex(siz_ex),
        .alu_ex(alu_ex), .opd_ex(opd_ex), .rpc_ex(rpc_ex), .sfr_ex(sfr_ex),
        .mul_mx(mul_mx), .bsf_mx(bsf_mx),
        .dwb_adr_o(dwb_adr_o), .dwb_sel_o(dwb_sel_o), .dwb_dat_o(dwb_dat_o),
        .dwb_wre_o(dwb_wre_o), .dwb_stb_o(dwb_stb_o), .dwb_ack_i(dwb_ack_i),
        .dwb_dat_i(dwb_dat_i), .dena(dena),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    always #5 gclk = ~gclk;

    typedef struct {
        logic [4:0]  rd;
        logic [2:0]  mux;
        logic [31:0] val;
        logic [1:0]  siz;
        logic [1:0]  a;
    } wr_t;

    typedef struct {
        logic [29:0] adr;
        logic [3:0]  sel;
        logic        wre;
        logic [31:0] dat;
    } bus_t;

    wr_t  wq[$];
    bus_t bq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   m_pending = 0, m_consumed = 0, m_launched = 0;
    int   dir_wait = -1, wait_cur = 0, cnt = 0;
    bit   spur = 0, fix_dat = 0;
    logic [31:0] fix_val = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_sel(input logic [1:0] siz, input logic [1:0] a);
        if (siz == 2'd0) return 4'b1000 >> a;
        if (siz == 2'd1) return a[1] ? 4'b0011 : 4'b1100;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] exp_st(input logic [1:0] siz, input logic [31:0] opd);
        if (siz == 2'd0) return (opd & 32'hFF) * 32'h0101_0101;
        if (siz == 2'd1) return (opd & 32'hFFFF) * 32'h0001_0001;
        return opd;
    endfunction

    function automatic logic [31:0] exp_ld(input logic [1:0] siz, input logic [1:0] a, input logic [31:0] d);
        if (siz == 2'd0) return (d >> (8 * (3 - a))) & 32'hFF;
        if (siz == 2'd1) return a[1] ? (d & 32'hFFFF) : (d >> 16);
        return d;
    endfunction

    // Reference model: consumes the EX instruction on every enabled edge.
    initial forever begin
        @(posedge gclk);
        m_consumed = 0;
        m_launched = 0;
        if (!grst) begin
            bit d;
            bus_t b;
            wr_t  w;
            d = iena && !(m_pending && !dwb_ack_i);
            if (d) begin
                m_consumed = 1;
                if (mux_ex == 3'd4 || str_ex) begin
                    b.adr = alu_ex[31:2];
                    b.sel = exp_sel(siz_ex, alu_ex[1:0]);
                    b.wre = str_ex;
                    b.dat = exp_st(siz_ex, opd_ex);
                    bq.push_back(b);
                    m_launched = 1;
                    m_pending  = 1;
                end else begin
                    m_pending = 0;
                end
                if (!str_ex && mux_ex != 3'd0 && rd_ex != 5'd0) begin
                    w.rd  = rd_ex;
                    w.mux = mux_ex;
                    w.siz = siz_ex;
                    w.a   = alu_ex[1:0];
                    w.val = (mux_ex == 3'd2) ? rpc_ex : (mux_ex == 3'd7) ? sfr_ex : alu_ex;
                    wq.push_back(w);
                end
            end
        end
    end

    // Monitor: checks enable, strobe, completed bus accesses and RF writes.
    initial forever begin
        @(negedge gclk);
        if (!grst) begin
            bit d;
            bus_t b;
            wr_t  w;
            logic [31:0] e;
            d = iena && !(m_pending && !dwb_ack_i);
            chk("dena", {31'd0, dena}, {31'd0, d});
            chk("dwb_stb_o", {31'd0, dwb_stb_o}, {31'd0, m_pending});
            if (d && m_pending) begin
                if (bq.size() == 0) begin
                    chk("bus_queue_nonempty", 32'd0, 32'd1);
                end else begin
                    b = bq.pop_front();
                    chk("dwb_adr_o", {2'b0, dwb_adr_o}, {2'b0, b.adr});
                    chk("dwb_sel_o", {28'd0, dwb_sel_o}, {28'd0, b.sel});
                    chk("dwb_wre_o", {31'd0, dwb_wre_o}, {31'd0, b.wre});
                    chk("dwb_dat_o", dwb_dat_o, b.dat);
                end
            end
            if (d && wq.size() != 0) begin
                w = wq.pop_front();
                case (w.mux)
                    3'd4:    e = exp_ld(w.siz, w.a, dwb_dat_i);
                    3'd5:    e = mul_mx;
                    3'd6:    e = bsf_mx;
                    default: e = w.val;
                endcase
                chk("rf_we", {31'd0, rf_we}, 32'd1);
                chk("rf_wa", {27'd0, rf_wa}, {27'd0, w.rd});
                chk("rf_wd", rf_wd, e);
            end else begin
                chk("rf_we_idle", {31'd0, rf_we}, 32'd0);
            end
        end
    end

    task automatic set_ex(input logic [2:0] mux, input logic [4:0] rd, input logic str,
                          input logic [1:0] siz, input logic [31:0] alu, input logic [31:0] opd);
        mux_ex = mux; rd_ex = rd; str_ex = str; siz_ex = siz;
        alu_ex = alu; opd_ex = opd; rpc_ex = $urandom; sfr_ex = $urandom;
    endtask

    // One clock: advance, then drive the bus responder and MX-side operands.
    task automatic step();
        @(posedge gclk);
        #1;
        if (m_pending) begin
            if (m_launched) begin
                cnt = 0;
                wait_cur = (dir_wait >= 0) ? dir_wait : int'($urandom_range(0, 3));
            end
            dwb_ack_i = (cnt >= wait_cur);
            cnt++;
        end else begin
            dwb_ack_i = spur || ((dir_wait < 0) && ($urandom_range(0, 9) == 0));
        end
        dwb_dat_i = fix_dat ? fix_val : $urandom;
        mul_mx = $urandom;
        bsf_mx = $urandom;
    endtask

    task automatic issue(input logic [2:0] mux, input logic [4:0] rd, input logic str,
                         input logic [1:0] siz, input logic [31:0] alu, input logic [31:0] opd);
        bit ok;
        ok = 0;
        set_ex(mux, rd, str, siz, alu, opd);
        iena = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (m_consumed) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_timeout: instruction not consumed within 50 cycles");
        end
        set_ex(3'd0, 5'd0, 1'b0, 2'd2, 32'h0, 32'h0);
    endtask

    task automatic drain(input int n);
        set_ex(3'd0, 5'd0, 1'b0, 2'd2, 32'h0, 32'h0);
        iena = 1'b1;
        repeat (n) step();
    endtask

    localparam logic [2:0] MUXTAB [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd4, 3'd5, 3'd6, 3'd7, 3'd4, 3'd1};

    initial begin
        grst = 1'b1; iena = 1'b1; dwb_ack_i = 1'b0; dwb_dat_i = 32'h0;
        mul_mx = 32'h0; bsf_mx = 32'h0;
        set_ex(3'd0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0);
        #12;
        chk("rst_stb", {31'd0, dwb_stb_o}, 32'd0);
        chk("rst_adr", {2'b0, dwb_adr_o}, 32'd0);
        chk("rst_sel", {28'd0, dwb_sel_o}, 32'd0);
        chk("rst_wre", {31'd0, dwb_wre_o}, 32'd0);
        chk("rst_dat", dwb_dat_o, 32'd0);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_dena_hi", {31'd0, dena}, 32'd1);
        iena = 1'b0;
        #1;
        chk("rst_dena_lo", {31'd0, dena}, 32'd0);
        iena = 1'b1;
        @(negedge gclk);
        grst = 1'b0;

        // ALU writeback
        dir_wait = 0;
        issue(3'd1, 5'd5, 1'b0, 2'd2, 32'h1234_5678, 32'h0);
        chk("alu_no_stb", {31'd0, dwb_stb_o}, 32'd0);
        drain(2);

        // Byte load, two wait states, fixed read data
        dir_wait = 2; fix_dat = 1; fix_val = 32'hAABB_CCDD;
        issue(3'd4, 5'd7, 1'b0, 2'd0, 32'h0000_0102, 32'h0);
        chk("bload_sel", {28'd0, dwb_sel_o}, 32'h2);
        chk("bload_adr", {2'b0, dwb_adr_o}, 32'h40);
        drain(5);
        fix_dat = 0;

        // Half store
        dir_wait = 1;
        issue(3'd0, 5'd3, 1'b1, 2'd1, 32'h0000_1006, 32'h0000_BEEF);
        chk("hst_sel", {28'd0, dwb_sel_o}, 32'h3);
        chk("hst_dat", dwb_dat_o, 32'hBEEF_BEEF);
        chk("hst_wre", {31'd0, dwb_wre_o}, 32'd1);
        drain(4);

        // Load to r0, then spurious acks while idle
        dir_wait = 0;
        issue(3'd4, 5'd0, 1'b0, 2'd2, 32'h0000_0100, 32'h0);
        drain(2);
        spur = 1;
        drain(3);
        spur = 0;

        // Back-to-back word loads with immediate acks
        issue(3'd4, 5'd8, 1'b0, 2'd2, 32'h0000_0200, 32'h0);
        issue(3'd4, 5'd9, 1'b0, 2'd2, 32'h0000_0204, 32'h0);
        chk("b2b_stb", {31'd0, dwb_stb_o}, 32'd1);
        drain(3);

        // Reset while a load is pending
        dir_wait = 5;
        issue(3'd4, 5'd10, 1'b0, 2'd2, 32'h0000_0300, 32'h0);
        step();
        #2;
        grst = 1'b1;
        #1;
        chk("rstmid_stb", {31'd0, dwb_stb_o}, 32'd0);
        chk("rstmid_rf_we", {31'd0, rf_we}, 32'd0);
        wq.delete();
        bq.delete();
        m_pending = 0;
        @(posedge gclk);
        #3;
        grst = 1'b0;
        dir_wait = 1;
        issue(3'd4, 5'd11, 1'b0, 2'd2, 32'h0000_0400, 32'h0);
        drain(4);

        // Randomized traffic
        dir_wait = -1;
        for (int i = 0; i < 3000; i++) begin
            logic       s;
            logic [4:0] r;
            step();
            s = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            set_ex(s ? 3'd0 : MUXTAB[$urandom_range(0, 9)], r, s,
                   2'($urandom_range(0, 2)), $urandom, $urandom);
            iena = ($urandom_range(0, 9) != 0);
        end
        drain(12);
        chk("final_wq_empty", wq.size(), 32'd0);
        chk("final_bq_empty", bq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
